// File: rtl/trace_serdes.sv
// Trace packer / stream unpacker for the FPGA side of the Data Trace Buffer.
// Packs 2**NTRACE_I lanes per cycle into WIDTH-bit words, or unpacks words back into lane slices.
module trace_serdes #(
   parameter int WIDTH       = 32,
   parameter int MAX_TRACES  = 8,
   parameter int NTRACE_BITS = 3
) (
   input  logic                       FPGA_CLK_I,
   input  logic                       RST_I,
   input  logic                       MODE_I,
   input  logic [NTRACE_BITS-1:0]     NTRACE_I,
   input  logic [1:0]                 TRIG_MODE_I,
   input  logic [MAX_TRACES-1:0]      TRIG_MASK_I,
   input  logic [MAX_TRACES-1:0]      TRIG_PATTERN_I,
   input  logic                       FPGA_TRIG_I,
   input  logic [MAX_TRACES-1:0]      FPGA_TRACE_I,
   output logic                       FPGA_WRITE_VALID_O,
   output logic                       TRG_EVENT_O,
   output logic [$clog2(WIDTH)-1:0]   EVENT_POS_O,
   output logic [WIDTH-1:0]           DATA_O,
   output logic                       STORE_VALID_O,
   input  logic                       STORE_READY_I,
   input  logic [WIDTH-1:0]           DATA_I,
   input  logic                       LOAD_VALID_I,
   output logic                       LOAD_READY_O,
   input  logic                       FPGA_READ_I,
   output logic [MAX_TRACES-1:0]      FPGA_STREAM_O,
   output logic                       FPGA_STREAM_VALID_O
);
   localparam int LOG_MT = $clog2(MAX_TRACES);
   localparam int PW     = $clog2(WIDTH);

   logic                   start_reg;
   logic                   mode_reg;
   logic [NTRACE_BITS-1:0] ntr_reg;
   logic [NTRACE_BITS-1:0] ntr_cl;
   logic                   changed;
   logic [PW:0]            n_val;
   logic [PW-1:0]          last_pos;
   logic [MAX_TRACES-1:0]  lane_mask;

   logic [WIDTH-1:0]       asm_reg;
   logic [WIDTH-1:0]       hold_reg;
   logic [WIDTH-1:0]       shadow_reg;
   logic [WIDTH-1:0]       stream_reg;
   logic [PW-1:0]          pos_reg;
   logic [PW-1:0]          spos_reg;
   logic [PW-1:0]          event_pos_reg;
   logic                   hold_full_reg;
   logic                   pending_reg;
   logic                   shadow_full_reg;
   logic                   svalid_reg;
   logic                   trg_reg;
   logic                   trig_prev_reg;

   logic                   write_valid;
   logic                   accept;
   logic                   store_fire;
   logic                   word_done;
   logic [WIDTH-1:0]       slot_mask;
   logic [WIDTH-1:0]       slot_data;
   logic [WIDTH-1:0]       asm_next;
   logic                   qual;
   logic                   stream_act;
   logic                   load_ready;
   logic                   load_fire;
   logic                   read_fire;
   logic                   slast;
   logic                   take;
   logic [MAX_TRACES-1:0]  slice;

   assign ntr_cl   = (NTRACE_I > NTRACE_BITS'(LOG_MT)) ? NTRACE_BITS'(LOG_MT) : NTRACE_I;
   assign n_val    = {{PW{1'b0}}, 1'b1} << ntr_cl;
   assign last_pos = PW'(WIDTH - int'(n_val));
   assign changed  = (MODE_I != mode_reg) || (ntr_cl != ntr_reg);

   for (genvar gi = 0; gi < MAX_TRACES; gi++) begin : g_lane
      assign lane_mask[gi] = (gi < int'(n_val));
   end

   // Capture path: a mode/width change cycle is a flush cycle, so no sample is taken then.
   assign write_valid = !pending_reg && !MODE_I && !changed;
   assign accept      = start_reg && write_valid;
   assign store_fire  = hold_full_reg && STORE_READY_I;
   assign word_done   = accept && (pos_reg == last_pos);
   assign slot_mask   = WIDTH'(lane_mask) << pos_reg;
   assign slot_data   = WIDTH'(FPGA_TRACE_I & lane_mask) << pos_reg;
   assign asm_next    = (asm_reg & ~slot_mask) | slot_data;

   always_comb begin
      qual = 1'b0;
      case (TRIG_MODE_I)
         2'b00:   qual = FPGA_TRIG_I;
         2'b01:   qual = FPGA_TRIG_I && !trig_prev_reg;
         2'b10:   qual = (((FPGA_TRACE_I ^ TRIG_PATTERN_I) & TRIG_MASK_I & lane_mask) == '0);
         default: qual = 1'b0;
      endcase
   end

   assign stream_act = start_reg && MODE_I && !changed;
   assign load_ready = stream_act && !shadow_full_reg;
   assign load_fire  = LOAD_VALID_I && load_ready;
   assign read_fire  = stream_act && FPGA_READ_I && svalid_reg;
   assign slast      = (spos_reg == last_pos);
   // Reload on the last-slice read keeps valid high with no bubble.
   assign take       = stream_act && shadow_full_reg && (!svalid_reg || (read_fire && slast));
   assign slice      = MAX_TRACES'(stream_reg >> spos_reg) & lane_mask;

   always_ff @(posedge FPGA_CLK_I) begin
      mode_reg <= MODE_I;
      ntr_reg  <= ntr_cl;
      if (RST_I) begin
         start_reg       <= 1'b0;
         asm_reg         <= '0;
         hold_reg        <= '0;
         shadow_reg      <= '0;
         stream_reg      <= '0;
         pos_reg         <= '0;
         spos_reg        <= '0;
         event_pos_reg   <= '0;
         hold_full_reg   <= 1'b0;
         pending_reg     <= 1'b0;
         shadow_full_reg <= 1'b0;
         svalid_reg      <= 1'b0;
         trg_reg         <= 1'b0;
         trig_prev_reg   <= 1'b0;
      end else begin
         start_reg <= 1'b1;
         if (start_reg) trig_prev_reg <= FPGA_TRIG_I;
         if (accept && qual && !trg_reg) begin
            trg_reg       <= 1'b1;
            event_pos_reg <= pos_reg;
         end

         if (store_fire) hold_full_reg <= 1'b0;
         if (changed) begin
            pos_reg     <= '0;
            asm_reg     <= '0;
            pending_reg <= 1'b0;
         end else if (pending_reg && store_fire) begin
            hold_reg      <= asm_reg;
            hold_full_reg <= 1'b1;
            pending_reg   <= 1'b0;
            asm_reg       <= '0;
         end else if (accept) begin
            if (word_done) begin
               pos_reg <= '0;
               if (!hold_full_reg || store_fire) begin
                  hold_reg      <= asm_next;
                  hold_full_reg <= 1'b1;
                  asm_reg       <= '0;
               end else begin
                  asm_reg     <= asm_next;
                  pending_reg <= 1'b1;
               end
            end else begin
               asm_reg <= asm_next;
               pos_reg <= pos_reg + PW'(n_val);
            end
         end

         if (changed) begin
            shadow_full_reg <= 1'b0;
            shadow_reg      <= '0;
            stream_reg      <= '0;
            svalid_reg      <= 1'b0;
            spos_reg        <= '0;
         end else begin
            if (load_fire) begin
               shadow_reg      <= DATA_I;
               shadow_full_reg <= 1'b1;
            end else if (take) begin
               shadow_full_reg <= 1'b0;
            end
            if (take) begin
               stream_reg <= shadow_reg;
               spos_reg   <= '0;
               svalid_reg <= 1'b1;
            end else if (read_fire) begin
               if (slast) begin
                  svalid_reg <= 1'b0;
                  spos_reg   <= '0;
               end else begin
                  spos_reg <= spos_reg + PW'(n_val);
               end
            end
         end
      end
   end

   assign FPGA_WRITE_VALID_O  = write_valid;
   assign TRG_EVENT_O         = trg_reg;
   assign EVENT_POS_O         = MODE_I ? '0 : event_pos_reg;
   assign DATA_O              = hold_reg;
   assign STORE_VALID_O       = hold_full_reg;
   assign LOAD_READY_O        = load_ready;
   assign FPGA_STREAM_O       = MODE_I ? slice : '0;
   assign FPGA_STREAM_VALID_O = MODE_I && svalid_reg;
endmodule

// File: tb/tb_trace_serdes.sv
// Self-checking bench for trace_serdes: directed scenarios plus randomized traffic
// compared against a word-queue / slice-queue reference model.
module tb_trace_serdes;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        mode = 1'b0;
   logic [2:0]  ntrace = 3'd3;
   logic [1:0]  trig_mode = 2'b11;
   logic [7:0]  trig_mask = 8'h00;
   logic [7:0]  trig_pattern = 8'h00;
   logic        trig = 1'b0;
   logic [7:0]  trace = 8'h00;
   logic        store_ready = 1'b1;
   logic [31:0] data_i = 32'h0;
   logic        load_valid = 1'b0;
   logic        fpga_read = 1'b0;

   logic        write_valid;
   logic        trg_event;
   logic [4:0]  event_pos;
   logic [31:0] data_o;
   logic        store_valid;
   logic        load_ready;
   logic [7:0]  stream;
   logic        stream_valid;

   trace_serdes #(.WIDTH(32), .MAX_TRACES(8), .NTRACE_BITS(3)) dut (
      .FPGA_CLK_I(clk), .RST_I(rst), .MODE_I(mode), .NTRACE_I(ntrace),
      .TRIG_MODE_I(trig_mode), .TRIG_MASK_I(trig_mask), .TRIG_PATTERN_I(trig_pattern),
      .FPGA_TRIG_I(trig), .FPGA_TRACE_I(trace), .FPGA_WRITE_VALID_O(write_valid),
      .TRG_EVENT_O(trg_event), .EVENT_POS_O(event_pos), .DATA_O(data_o),
      .STORE_VALID_O(store_valid), .STORE_READY_I(store_ready), .DATA_I(data_i),
      .LOAD_VALID_I(load_valid), .LOAD_READY_O(load_ready), .FPGA_READ_I(fpga_read),
      .FPGA_STREAM_O(stream), .FPGA_STREAM_VALID_O(stream_valid)
   );

   int total = 0;
   int bad = 0;

   // reference model state
   bit          m_start, m_trg, m_tprev, m_mode_c;
   int          m_evpos, m_ncl_c, m_pos;
   logic [31:0] m_asm;
   logic [31:0] m_words[$];
   logic [7:0]  s_q[$];
   int          s_reads, s_first, s_last, cyc;
   bit          s_loaded;

   logic [7:0]  t1v[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [31:0] w5[2] = '{32'hA3A2A1A0, 32'hB3B2B1B0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ncl(input logic [2:0] v);
      return (v > 3'd3) ? 3 : int'(v);
   endfunction

   // One clock cycle: check outputs against the model, then advance the model at the edge.
   task automatic step();
      int nl;
      bit changed, wv, acc, q, fire, had_two;
      logic [7:0] lm;
      nl = 1 << ncl(ntrace);
      lm = 8'((1 << nl) - 1);
      changed = (mode != m_mode_c) || (ncl(ntrace) != m_ncl_c);
      wv = !mode && !changed && (m_words.size() < 2);
      s_loaded = 1'b0;
      #1;
      if (!rst) begin
         chk("write_valid", 32'(write_valid), 32'(wv));
         chk("store_valid", 32'(store_valid), 32'(m_words.size() > 0));
         if (m_words.size() > 0) chk("data_o", data_o, m_words[0]);
         chk("trg_event", 32'(trg_event), 32'(m_trg));
         chk("event_pos", 32'(event_pos), mode ? 32'd0 : 32'(m_evpos));
         if (!mode) begin
            chk("load_ready_trace", 32'(load_ready), 32'd0);
            chk("stream_valid_trace", 32'(stream_valid), 32'd0);
         end else begin
            if (stream_valid && fpga_read) begin
               chk("stream_avail", 32'(s_q.size() > 0), 32'd1);
               if (s_q.size() > 0) chk("stream_o", 32'(stream), 32'(s_q.pop_front()));
               s_reads++;
               if (s_first < 0) s_first = cyc;
               s_last = cyc;
            end
            if (load_valid && load_ready) begin
               for (int k = 0; k < 32 / nl; k++) s_q.push_back(8'((data_i >> (k * nl)) & 32'(lm)));
               s_loaded = 1'b1;
            end
         end
      end
      @(posedge clk);
      cyc++;
      fire = store_ready && (m_words.size() > 0);
      if (rst) begin
         m_start = 0; m_trg = 0; m_evpos = 0; m_tprev = 0; m_asm = '0; m_pos = 0;
         m_words.delete();
      end else begin
         acc = m_start && wv;
         case (trig_mode)
            2'b00:   q = trig;
            2'b01:   q = trig && !m_tprev;
            2'b10:   q = (((trace ^ trig_pattern) & trig_mask & lm) == 8'h00);
            default: q = 1'b0;
         endcase
         if (acc && q && !m_trg) begin m_trg = 1; m_evpos = m_pos; end
         if (m_start) m_tprev = trig;
         had_two = (m_words.size() == 2);
         if (fire) void'(m_words.pop_front());
         if (changed) begin
            if (had_two) void'(m_words.pop_back());
            m_asm = '0; m_pos = 0;
         end else if (acc) begin
            for (int l = 0; l < nl; l++) m_asm[m_pos + l] = trace[l];
            m_pos += nl;
            if (m_pos == 32) begin m_words.push_back(m_asm); m_asm = '0; m_pos = 0; end
         end
         m_start = 1;
      end
      m_mode_c = mode;
      m_ncl_c = ncl(ntrace);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_q.delete();
      s_reads = 0; s_first = -1; s_last = -1;
      repeat (3) step();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] exp6;
      int idx;
      logic [1:0] v;
      @(negedge clk);

      // 1: four n=8 samples pack into one word, store accepted at once
      mode = 0; ntrace = 3; store_ready = 1; trig_mode = 2'b11;
      do_reset();
      trace = 8'h00; step();
      for (int i = 0; i < 4; i++) begin trace = t1v[i]; step(); end
      #1;
      chk("t1_store_valid", 32'(store_valid), 32'd1);
      chk("t1_data", data_o, 32'h44332211);
      trace = 8'h55; step();
      #1;
      chk("t1_pulse", 32'(store_valid), 32'd0);

      // 2: backpressure, second word goes pending
      store_ready = 0;
      do_reset();
      trace = 8'h00; step();
      for (int i = 0; i < 10; i++) begin
         trace = 8'($urandom);
         step();
         if (i == 7) begin #1; chk("t2_wv_low", 32'(write_valid), 32'd0); end
      end
      store_ready = 1;
      for (int i = 0; i < 8; i++) begin trace = 8'($urandom); step(); end

      // 3: pattern trigger at pos 10 with n=2
      ntrace = 1; trig_mode = 2'b10; trig_mask = 8'h03; trig_pattern = 8'h02;
      do_reset();
      trace = 8'h00; step();
      for (int i = 0; i < 5; i++) begin
         v = 2'($urandom_range(0, 2));
         if (v == 2'd2) v = 2'd3;
         trace = {6'($urandom), v};
         step();
      end
      trace = {6'($urandom), 2'b10}; step();
      #1;
      chk("t3_trg", 32'(trg_event), 32'd1);
      chk("t3_pos", 32'(event_pos), 32'd10);
      for (int i = 0; i < 6; i++) begin trace = 8'($urandom); step(); end
      trace = 8'h02; step();
      #1;
      chk("t3_pos_kept", 32'(event_pos), 32'd10);

      // 4: edge trigger held high from reset, then disabled trigger
      ntrace = 3; trig_mode = 2'b01; trig = 1;
      do_reset();
      trace = 8'h00; step();
      trace = 8'h01; step();
      #1;
      chk("t4_edge_trg", 32'(trg_event), 32'd1);
      chk("t4_edge_pos", 32'(event_pos), 32'd0);
      for (int i = 0; i < 5; i++) step();
      trig_mode = 2'b11;
      do_reset();
      for (int i = 0; i < 20; i++) begin trig = ~trig; trace = 8'($urandom); step(); end
      #1;
      chk("t4_disabled", 32'(trg_event), 32'd0);
      trig = 0;

      // randomized trace traffic
      for (int r = 0; r < 4; r++) begin
         ntrace = 3'($urandom_range(0, 7));
         trig_mode = 2'($urandom);
         trig_mask = 8'($urandom);
         trig_pattern = 8'($urandom);
         do_reset();
         for (int i = 0; i < 200; i++) begin
            trace = 8'($urandom);
            trig = 1'($urandom);
            store_ready = ($urandom % 3) != 0;
            step();
         end
      end
      store_ready = 1; trig = 0; trig_mode = 2'b11;

      // 5: stream two words back-to-back, n=8
      mode = 1; ntrace = 3; fpga_read = 1;
      do_reset();
      idx = 0; load_valid = 1; data_i = w5[0];
      for (int i = 0; i < 20; i++) begin
         step();
         if (s_loaded) idx++;
         if (idx < 2) data_i = w5[idx];
         else load_valid = 0;
      end
      chk("t5_reads", 32'(s_reads), 32'd8);
      chk("t5_contig", 32'(s_last - s_first + 1), 32'd8);
      chk("t5_drained", 32'(s_q.size()), 32'd0);
      #1;
      chk("t5_valid_drop", 32'(stream_valid), 32'd0);

      // randomized stream traffic
      for (int r = 0; r < 3; r++) begin
         ntrace = 3'($urandom_range(0, 7));
         do_reset();
         load_valid = 0;
         for (int i = 0; i < 300; i++) begin
            if (!load_valid || s_loaded) begin
               load_valid = 1'($urandom);
               data_i = $urandom;
            end
            fpga_read = ($urandom % 4) != 0;
            step();
         end
         chk("rs_progress", 32'(s_reads > 0), 32'd1);
      end
      load_valid = 0; fpga_read = 0;

      // 6: lane count change mid-word flushes the partial word
      mode = 0; ntrace = 3; store_ready = 1;
      do_reset();
      trace = 8'h00; step();
      trace = 8'hAA; step();
      trace = 8'hBB; step();
      ntrace = 1; trace = 8'hFF; step();
      exp6 = '0;
      for (int k = 0; k < 16; k++) begin
         trace = 8'($urandom);
         exp6 = exp6 | (32'(trace[1:0]) << (2 * k));
         step();
      end
      #1;
      chk("t6_valid", 32'(store_valid), 32'd1);
      chk("t6_word", data_o, exp6);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
